// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard controller.
package hazard_forward_ctrl_pkg;

   // Register-specifier width of the shadow entries; the top's REG_W must match.
   localparam int SHADOW_REG_W = 5;

   // Forward select encoding for the EX operand muxes (2'h3 is never driven).
   localparam logic [1:0] FWD_REG   = 2'h0;
   localparam logic [1:0] FWD_WB    = 2'h1;
   localparam logic [1:0] FWD_EXMEM = 2'h2;

   // Architectural zero register: never forwarded, never causes a stall.
   localparam logic [SHADOW_REG_W-1:0] REG_ZERO = '0;

   // Destination info for one pipeline stage (ID/EX or EX/MEM).
   typedef struct packed {
      logic                    valid;
      logic [SHADOW_REG_W-1:0] dest;
      logic                    wr;
      logic                    ld;
   } shadow_t;

   // True when the stage entry will write register r and r is not $0.
   function automatic logic writes_reg(shadow_t e, logic [SHADOW_REG_W-1:0] r);
      return e.valid && e.wr && (e.dest == r) && (r != REG_ZERO);
   endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Priority comparator choosing the operand source for one EX operand.
module fwd_select
   import hazard_forward_ctrl_pkg::*;
(
   input  logic [SHADOW_REG_W-1:0] src,
   input  shadow_t                 s_ex,
   input  shadow_t                 s_mem,
   output logic [1:0]              sel
);

   // A load sitting in ID/EX has no result yet; the hazard stall keeps its
   // consumer out of EX, so excluding it here only guards an impossible case.
   logic unused_mem_ld;
   assign unused_mem_ld = s_mem.ld;

   // Youngest producer wins: EX/MEM result before WB data before the register file.
   always_comb begin
      sel = FWD_REG;
      if (writes_reg(s_ex, src) && !s_ex.ld) begin
         sel = FWD_EXMEM;
      end else if (writes_reg(s_mem, src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select and load-use hazard controller for the EX stage.
// Keeps a shadow of the ID/EX and EX/MEM destination info, registers the
// operand-A/B forward selects on the edge an instruction enters EX, and
// stalls/bubbles on a load-use dependency with a saturating stall counter.
module hazard_forward_ctrl
   import hazard_forward_ctrl_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             flush,
   input  logic             hold,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic             stall,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_count
);

   shadow_t          s_ex;
   shadow_t          s_mem;
   shadow_t          id_entry;
   logic [REG_W-1:0] src_b;
   logic [1:0]       sel_a;
   logic [1:0]       sel_b;
   logic             hazard;

   // Operand B only depends on rt when the instruction actually reads it.
   assign src_b = id_uses_rt ? id_rt : REG_ZERO;

   // Load in ID/EX whose result the ID instruction needs: wait one cycle.
   always_comb begin
      hazard = id_valid && s_ex.valid && s_ex.ld && (s_ex.dest != REG_ZERO) &&
               ((s_ex.dest == id_rs) || (id_uses_rt && (s_ex.dest == id_rt)));
   end

   // A flush kills the ID instruction, so it overrides the stall.
   assign stall  = hazard && !flush;
   assign bubble = stall || flush;

   // What enters ID/EX on the next advancing edge; a bubble clears valid.
   assign id_entry = '{valid: id_valid && !stall && !flush,
                       dest:  id_dest,
                       wr:    id_reg_write,
                       ld:    id_mem_read};

   fwd_select u_fwd_a (
      .src   (id_rs),
      .s_ex  (s_ex),
      .s_mem (s_mem),
      .sel   (sel_a)
   );

   fwd_select u_fwd_b (
      .src   (src_b),
      .s_ex  (s_ex),
      .s_mem (s_mem),
      .sel   (sel_b)
   );

   // Advance shadows, register selects for the EX instruction, count stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_ex        <= '0;
         s_mem       <= '0;
         forward_a   <= FWD_REG;
         forward_b   <= FWD_REG;
         stall_count <= '0;
      end else if (!hold) begin
         s_mem     <= s_ex;
         s_ex      <= id_entry;
         forward_a <= id_entry.valid ? sel_a : FWD_REG;
         forward_b <= id_entry.valid ? sel_b : FWD_REG;
         if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
         end
      end
   end

endmodule
